// File: rtl/matrix_pkg.sv
// Shared types, colour/key constants and pixel addressing helpers for the
// keypad-driven LED matrix frame-buffer writer.
package matrix_pkg;

    localparam int unsigned NUM_KEYS = 16;
    localparam int unsigned KEY_W    = 4;
    localparam int unsigned PIX_W    = 2;
    localparam int unsigned NUM_PIX  = 64;
    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned POS_W    = 3;
    localparam int unsigned FRAME_W  = NUM_PIX * PIX_W;
    localparam int unsigned OFF_W    = 7;

    typedef logic [PIX_W-1:0] colour_t;

    localparam colour_t COL_OFF   = 2'b00;
    localparam colour_t COL_RED   = 2'b10;
    localparam colour_t COL_GREEN = 2'b01;
    localparam colour_t COL_YEL   = 2'b11;

    localparam logic [KEY_W-1:0] KEY_UP    = 4'd1;
    localparam logic [KEY_W-1:0] KEY_LEFT  = 4'd4;
    localparam logic [KEY_W-1:0] KEY_CYCLE = 4'd5;
    localparam logic [KEY_W-1:0] KEY_RIGHT = 4'd6;
    localparam logic [KEY_W-1:0] KEY_YEL   = 4'd7;
    localparam logic [KEY_W-1:0] KEY_DOWN  = 4'd9;
    localparam logic [KEY_W-1:0] KEY_OFF   = 4'd12;
    localparam logic [KEY_W-1:0] KEY_RED   = 4'd13;
    localparam logic [KEY_W-1:0] KEY_GREEN = 4'd14;
    localparam logic [KEY_W-1:0] KEY_CLEAR = 4'd15;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [KEY_W-1:0] code;
    } press_t;

    // Pixel 0 (row 0, col 0) lives in the top two bits of the frame word.
    function automatic logic [OFF_W-1:0] pix_offset(input logic [ADDR_W-1:0] idx);
        return OFF_W'(7'd126 - {idx, 1'b0});
    endfunction

    function automatic colour_t colour_next(input colour_t c);
        case (c)
            COL_OFF:   return COL_RED;
            COL_RED:   return COL_GREEN;
            COL_GREEN: return COL_YEL;
            default:   return COL_OFF;
        endcase
    endfunction

endpackage

// File: rtl/key_edge.sv
// Two-stage key sampler with rising-edge detect; reports the lowest-index
// newly pressed key each cycle.
module key_edge
    import matrix_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_i,
    output press_t              press_o
);

    logic [NUM_KEYS-1:0] k_q;
    logic [NUM_KEYS-1:0] k_qq;
    logic [NUM_KEYS-1:0] rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q  <= '0;
            k_qq <= '0;
        end else begin
            k_q  <= key_i;
            k_qq <= k_q;
        end
    end

    assign rise = k_q & ~k_qq;

    // Scan high to low so the lowest set index is the one that sticks.
    always_comb begin
        press_o = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (rise[i]) begin
                press_o.valid = 1'b1;
                press_o.code  = KEY_W'(i);
            end
        end
    end

endmodule

// File: rtl/matrix_painter.sv
// Keypad-driven 8x8 bicolour frame-buffer writer: cursor movement, pixel
// painting, full-clear sweep and blinking cursor overlay.
module matrix_painter
    import matrix_pkg::*;
#(
    parameter int unsigned BLINK_DIV = 12_500_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_state_i,
    output logic [FRAME_W-1:0]  frame_o,
    output logic [POS_W-1:0]    cursor_row_o,
    output logic [POS_W-1:0]    cursor_col_o,
    output logic                busy_o
);

    localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    press_t               press;
    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [POS_W-1:0]     row_q, row_d;
    logic [POS_W-1:0]     col_q, col_d;
    logic [FRAME_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 phase_q, phase_d;
    logic [ADDR_W-1:0]    cur_idx;
    colour_t              cur_pix;
    logic                 paint;
    colour_t              paint_col;

    key_edge u_key_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_i   (key_state_i),
        .press_o (press)
    );

    assign cur_idx = {row_q, col_q};
    assign cur_pix = buf_q[pix_offset(cur_idx) +: PIX_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            col_q   <= col_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // Key dispatch in IDLE; one pixel zeroed per cycle in CLEAR.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        row_d     = row_q;
        col_d     = col_q;
        buf_d     = buf_q;
        paint     = 1'b0;
        paint_col = COL_OFF;

        case (state_q)
            ST_IDLE: begin
                if (press.valid) begin
                    case (press.code)
                        KEY_UP:    row_d = row_q - POS_W'(1);
                        KEY_DOWN:  row_d = row_q + POS_W'(1);
                        KEY_LEFT:  col_d = col_q - POS_W'(1);
                        KEY_RIGHT: col_d = col_q + POS_W'(1);
                        KEY_CYCLE: begin
                            paint     = 1'b1;
                            paint_col = colour_next(cur_pix);
                        end
                        KEY_OFF: begin
                            paint     = 1'b1;
                            paint_col = COL_OFF;
                        end
                        KEY_RED: begin
                            paint     = 1'b1;
                            paint_col = COL_RED;
                        end
                        KEY_GREEN: begin
                            paint     = 1'b1;
                            paint_col = COL_GREEN;
                        end
                        KEY_YEL: begin
                            paint     = 1'b1;
                            paint_col = COL_YEL;
                        end
                        KEY_CLEAR: begin
                            state_d = ST_CLEAR;
                            addr_d  = '0;
                        end
                        default: ;
                    endcase
                end
                if (paint) begin
                    buf_d[pix_offset(cur_idx) +: PIX_W] = paint_col;
                end
            end
            ST_CLEAR: begin
                buf_d[pix_offset(addr_q) +: PIX_W] = COL_OFF;
                addr_d = addr_q + ADDR_W'(1);
                if (addr_q == ADDR_W'(NUM_PIX - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Free-running blink divider.
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
        if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    // Cursor overlay is display-only; the stored buffer is never touched.
    always_comb begin
        frame_o = buf_q;
        if (phase_q && (state_q == ST_IDLE)) begin
            frame_o[pix_offset(cur_idx) +: PIX_W] = (cur_pix == COL_OFF) ? COL_YEL : COL_OFF;
        end
    end

    assign cursor_row_o = row_q;
    assign cursor_col_o = col_q;
    assign busy_o       = (state_q == ST_CLEAR);

endmodule
